// File: rtl/imm_split_seq.sv
// Splits one operand word into a high then low set-immediate micro-op.
// Replaying both halves onto a register reproduces the original word.
module imm_split_seq #(
  parameter int W_OPR = 32,
  parameter int W_IMM = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             val_i,
  input  logic [W_OPR-1:0] value_i,
  output logic             ready_o,
  output logic             set_valid_o,
  input  logic             set_ready_i,
  output logic [W_IMM-1:0] set_imm_o,
  output logic             set_high_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT_HIGH = 2'd1,
    EMIT_LOW  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W_OPR-1:0] held;
  logic             accept;
  logic             retire;
  logic             low_done;

  assign accept = val_i & ready_o;
  assign retire = set_valid_o & set_ready_i;

  always_comb begin
    state_nxt   = state;
    ready_o     = 1'b0;
    set_valid_o = 1'b0;
    set_high_o  = 1'b0;
    set_imm_o   = '0;
    low_done    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_o = !flush_i;
        if (accept)
          state_nxt = EMIT_HIGH;
      end
      EMIT_HIGH: begin
        set_valid_o = 1'b1;
        set_high_o  = 1'b1;
        set_imm_o   = held[W_OPR-1:W_IMM];
        if (retire)
          state_nxt = EMIT_LOW;
      end
      EMIT_LOW: begin
        set_valid_o = 1'b1;
        set_imm_o   = held[W_IMM-1:0];
        ready_o     = !flush_i & set_ready_i;
        if (retire) begin
          low_done  = 1'b1;
          state_nxt = accept ? EMIT_HIGH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Flush overrides everything, including a same-cycle retire.
    if (flush_i)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      held   <= '0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_o <= low_done & !flush_i;
      if (accept)
        held <= value_i;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_imm_split_seq.sv
// Directed vector table, reset/corner sequences and a random replay
// scoreboard for imm_split_seq.
module tb_imm_split_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        val;
  logic [31:0] value;
  logic        ready;
  logic        set_valid;
  logic        set_ready;
  logic [15:0] set_imm;
  logic        set_high;
  logic        busy;
  logic        done;

  imm_split_seq #(.W_OPR(32), .W_IMM(16)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .val_i       (val),
    .value_i     (value),
    .ready_o     (ready),
    .set_valid_o (set_valid),
    .set_ready_i (set_ready),
    .set_imm_o   (set_imm),
    .set_high_o  (set_high),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        val;
    logic [31:0] value;
    logic        srdy;
    logic        flush;
    logic [20:0] exp;
  } vec_t;

  vec_t vq[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  function automatic logic [20:0] outs();
    return {ready, set_valid, set_imm, set_high, busy, done};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic [31:0] d,
                     input logic sr, input logic fl,
                     input logic e_rdy, input logic e_vld,
                     input logic [15:0] e_imm, input logic e_hi,
                     input logic e_busy, input logic e_done);
    vec_t t;
    t.val   = v;
    t.value = d;
    t.srdy  = sr;
    t.flush = fl;
    t.exp   = {e_rdy, e_vld, e_imm, e_hi, e_busy, e_done};
    vq.push_back(t);
  endtask

  task automatic idle_in();
    val = 1'b0; value = '0; flush = 1'b0; set_ready = 1'b1;
  endtask

  logic [31:0] model_reg;
  logic [31:0] exp_q[$];
  int          n_acc;
  int          n_done;
  int          cyc;

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    #1 check("reset_outs", 64'(outs()), 64'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;

    // single word
    add(1, 32'h1234ABCD, 1, 0, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 0,            1, 0, 0, 1, 16'h1234, 1, 1, 0);
    add(0, 0,            1, 0, 1, 1, 16'hABCD, 0, 1, 0);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 1);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 0);
    // backpressure: 3 stalls in each emit state
    add(1, 32'h1234ABCD, 1, 0, 1, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0,          0, 0, 0, 1, 16'h1234, 1, 1, 0);
    add(0, 0,            1, 0, 0, 1, 16'h1234, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0,          0, 0, 0, 1, 16'hABCD, 0, 1, 0);
    add(0, 0,            1, 0, 1, 1, 16'hABCD, 0, 1, 0);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 1);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 0);
    // back-to-back
    add(1, 32'hFFFF0000, 1, 0, 1, 0, 16'h0000, 0, 0, 0);
    add(1, 32'h00018000, 1, 0, 0, 1, 16'hFFFF, 1, 1, 0);
    add(1, 32'h00018000, 1, 0, 1, 1, 16'h0000, 0, 1, 0);
    add(0, 0,            1, 0, 0, 1, 16'h0001, 1, 1, 1);
    add(0, 0,            1, 0, 1, 1, 16'h8000, 0, 1, 0);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 1);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 0);
    // flush in EMIT_LOW with a word waiting
    add(1, 32'hDEADBEEF, 1, 0, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 0,            1, 0, 0, 1, 16'hDEAD, 1, 1, 0);
    add(1, 32'h11112222, 1, 1, 0, 1, 16'hBEEF, 0, 1, 0);
    add(1, 32'h11112222, 1, 0, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 0,            1, 0, 0, 1, 16'h1111, 1, 1, 0);
    add(0, 0,            1, 0, 1, 1, 16'h2222, 0, 1, 0);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 1);
    add(0, 0,            1, 0, 1, 0, 16'h0000, 0, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      val = vq[i].val; value = vq[i].value;
      set_ready = vq[i].srdy; flush = vq[i].flush;
      #1 check($sformatf("vec%0d", i), 64'(outs()), 64'(vq[i].exp));
    end

    // async reset while in EMIT_HIGH
    @(negedge clk);
    val = 1'b1; value = 32'hCAFEF00D; set_ready = 1'b0;
    @(negedge clk);
    val = 1'b0;
    #1 check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 check("rst_mid_outs", 64'(outs()), 64'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    set_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("post_rst%0d", i), 64'({ready, busy, done}), 64'(3'b100));
    end

    // random replay scoreboard
    model_reg = {$urandom};
    n_acc = 0; n_done = 0; cyc = 0;
    while (n_done < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      set_ready = ($urandom_range(0, 9) < 7);
      val = (n_acc < 1000) && ($urandom_range(0, 1) == 1);
      value = {$urandom};
      #1;
      if (done) begin
        n_done++;
        if (exp_q.size() == 0)
          check("replay_underflow", 64'(n_done), 64'(0));
        else
          check($sformatf("replay%0d", n_done), 64'(model_reg),
                64'(exp_q.pop_front()));
      end
      if (set_valid && set_ready) begin
        if (set_high) model_reg[31:16] = set_imm;
        else          model_reg[15:0]  = set_imm;
      end
      if (val && ready) begin
        exp_q.push_back(value);
        n_acc++;
      end
    end
    check("replay_count", 64'(n_done), 64'd1000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
